// File: rtl/inst_mem_loadable.sv
// ==========================================================================
// inst_mem_loadable : sync-read instruction memory, self-clear + stream load
// Revision 1.0
// ==========================================================================
`default_nettype none

module inst_mem_loadable #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int DEPTH_LOG2     = 10,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [ADDR_W-1:0]     addr,
   output logic                  ready,
   output logic [DATA_W-1:0]     data,
   output logic                  data_valid,
   output logic                  addr_err,
   output logic                  busy,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [DATA_W-1:0]     load_data,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic [DEPTH_LOG2:0]   load_count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] c_idx_last = '1;
   localparam logic [DEPTH_LOG2-1:0] c_idx_one  = 1;
   localparam logic [DEPTH_LOG2:0]   c_cnt_one  = 1;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   logic [DATA_W-1:0]     mem_q [DEPTH];

   state_t                state_q,      state_d;
   logic [DEPTH_LOG2-1:0] clr_cnt_q,    clr_cnt_d;
   logic [DEPTH_LOG2-1:0] ptr_q,        ptr_d;
   logic [DEPTH_LOG2:0]   load_count_q, load_count_d;
   logic [DATA_W-1:0]     data_q,       data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  addr_err_q,   addr_err_d;

   logic                  w_mem_we;
   logic [DEPTH_LOG2-1:0] w_mem_waddr;
   logic [DATA_W-1:0]     w_mem_wdata;
   logic [DEPTH_LOG2-1:0] w_rd_idx;
   logic [ADDR_W-1:0]     w_addr_hi;
   logic                  w_addr_bad;

   assign w_rd_idx   = addr[DEPTH_LOG2+1:2];
   assign w_addr_hi  = addr >> (DEPTH_LOG2 + 2);
   assign w_addr_bad = (addr[1:0] != 2'b00) || (w_addr_hi != '0);

   assign ready      = (state_q == ST_RUN) && ce && !load_start;
   assign busy       = (state_q != ST_RUN);
   assign load_ready = (state_q == ST_LOAD);
   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign addr_err   = addr_err_q;
   assign load_count = load_count_q;

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      ptr_d        = ptr_q;
      load_count_d = load_count_q;
      data_d       = '0;
      data_valid_d = 1'b0;
      addr_err_d   = 1'b0;
      w_mem_we     = 1'b0;
      w_mem_waddr  = clr_cnt_q;
      w_mem_wdata  = '0;

      unique case (state_q)
         ST_CLEAR: begin
            w_mem_we  = 1'b1;
            clr_cnt_d = clr_cnt_q + c_idx_one;
            if (clr_cnt_q == c_idx_last) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (load_start) begin
               state_d      = ST_LOAD;
               ptr_d        = '0;
               load_count_d = '0;
            end else if (ce) begin
               data_valid_d = 1'b1;
               addr_err_d   = w_addr_bad;
               data_d       = w_addr_bad ? '0 : mem_q[w_rd_idx];
            end
         end
         ST_LOAD: begin
            if (load_valid) begin
               w_mem_we     = 1'b1;
               w_mem_waddr  = ptr_q;
               w_mem_wdata  = load_data;
               ptr_d        = ptr_q + c_idx_one;
               load_count_d = load_count_q + c_cnt_one;
               // Writing the top word ends the load even without load_last.
               if (load_last || (ptr_q == c_idx_last)) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase

      // A reset cycle must not disturb the array.
      if (!rst) begin
         w_mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         clr_cnt_q    <= '0;
         ptr_q        <= '0;
         load_count_q <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         ptr_q        <= ptr_d;
         load_count_q <= load_count_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         addr_err_q   <= addr_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         mem_q[w_mem_waddr] <= w_mem_wdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loadable.sv
// ==========================================================================
// tb_inst_mem_loadable : vector table + scoreboard bench for inst_mem_loadable
// Revision 1.0
// ==========================================================================
`default_nettype none

module tb_inst_mem_loadable;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] data;
   logic        data_valid;
   logic        addr_err;
   logic        busy;
   logic        load_start;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic [10:0] load_count;

   inst_mem_loadable #(
      .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .CLEAR_ON_RESET(1)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr), .ready(ready),
      .data(data), .data_valid(data_valid), .addr_err(addr_err), .busy(busy),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(load_ready), .load_count(load_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] d;
      logic        v;
      logic        e;
      string       name;
   } sb_t;

   typedef struct {
      logic        ce;
      logic [31:0] a;
      logic [31:0] d;
      logic        v;
      logic        e;
      string       name;
   } vec_t;

   sb_t         sb[$];
   vec_t        vecs[$];
   logic [31:0] img[$];
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Pop and compare every fetch whose result is due by now.
   task automatic drain();
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         sb_t e;
         e = sb.pop_front();
         if (e.due < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: result missed (due %0d, now %0d)", e.name, e.due, cyc);
         end else begin
            chk({e.name, ".data"},  64'(data),       64'(e.d));
            chk({e.name, ".valid"}, 64'(data_valid), 64'(e.v));
            chk({e.name, ".err"},   64'(addr_err),   64'(e.e));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic fetch(input logic en, input logic [31:0] a, input logic [31:0] d,
                        input logic v, input logic e, input string name);
      sb_t s;
      ce = en;
      addr = a;
      s.due = cyc + 1; s.d = d; s.v = v; s.e = e; s.name = name;
      sb.push_back(s);
      tick();
      ce = 1'b0;
   endtask

   task automatic wait_idle(input string name, output int n);
      n = 0;
      while (busy && n < 3000) begin
         n++;
         tick();
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s: still busy after %0d cycles", name, n);
      end
   endtask

   // Stream img[] into the memory; stall cycles are inserted before each word.
   task automatic load_img(input int stalls, input bit use_last, input string name);
      ce = 1'b1;
      addr = 32'h0;
      load_start = 1'b1;
      #1;
      chk({name, ".ready_on_start"}, 64'(ready), 64'(0));
      tick();
      load_start = 1'b0;
      ce = 1'b0;
      chk({name, ".load_ready"}, 64'(load_ready), 64'(1));
      chk({name, ".valid_in_load"}, 64'(data_valid), 64'(0));
      chk({name, ".count_start"}, 64'(load_count), 64'(0));
      for (int i = 0; i < img.size(); i++) begin
         for (int s = 0; s < stalls; s++) begin
            load_valid = 1'b0;
            tick();
            chk($sformatf("%s.stall_count%0d", name, i), 64'(load_count), 64'(i));
         end
         load_valid = 1'b1;
         load_data  = img[i];
         load_last  = use_last && (i == img.size() - 1);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic build_table();
      vecs.delete();
      vecs.push_back('{1'b1, 32'h4,        32'h34020020, 1'b1, 1'b0, "f_0x4"});
      vecs.push_back('{1'b1, 32'h8,        32'h3403ff00, 1'b1, 1'b0, "f_0x8_b2b"});
      vecs.push_back('{1'b1, 32'h0,        32'h34011100, 1'b1, 1'b0, "f_0x0"});
      vecs.push_back('{1'b1, 32'h6,        32'h0,        1'b1, 1'b1, "f_misalign"});
      vecs.push_back('{1'b1, 32'h1000,     32'h0,        1'b1, 1'b1, "f_range"});
      vecs.push_back('{1'b1, 32'hC,        32'h0,        1'b1, 1'b0, "f_cleared"});
      vecs.push_back('{1'b0, 32'h4,        32'h0,        1'b0, 1'b0, "f_disable"});
      vecs.push_back('{1'b1, 32'hFFC,      32'h0,        1'b1, 1'b0, "f_top_clear"});
      vecs.push_back('{1'b1, 32'h80000000, 32'h0,        1'b1, 1'b1, "f_hibit"});
      vecs.push_back('{1'b1, 32'h8,        32'h3403ff00, 1'b1, 1'b0, "f_after_err"});
   endtask

   initial begin
      int n;
      rst = 1'b0; ce = 1'b0; addr = '0;
      load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;

      tick();
      tick();
      chk("rst.data",   64'(data),       64'(0));
      chk("rst.valid",  64'(data_valid), 64'(0));
      chk("rst.err",    64'(addr_err),   64'(0));
      chk("rst.count",  64'(load_count), 64'(0));
      chk("rst.busy",   64'(busy),       64'(1));
      rst = 1'b1;

      ce = 1'b1;
      #1;
      chk("clear.ready", 64'(ready), 64'(0));
      ce = 1'b0;
      wait_idle("clear", n);
      chk("clear.cycles", 64'(n), 64'(1024));
      ce = 1'b1;
      #1;
      chk("run.ready", 64'(ready), 64'(1));
      chk("run.load_ready", 64'(load_ready), 64'(0));
      fetch(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, "f_after_clear");

      img = '{32'h34011100, 32'h34020020, 32'h3403ff00};
      load_img(0, 1'b1, "load3");
      chk("load3.count", 64'(load_count), 64'(3));
      chk("load3.busy",  64'(busy),       64'(0));

      build_table();
      for (int i = 0; i < vecs.size(); i++) begin
         fetch(vecs[i].ce, vecs[i].a, vecs[i].d, vecs[i].v, vecs[i].e, vecs[i].name);
      end

      load_img(2, 1'b1, "stall3");
      chk("stall3.count", 64'(load_count), 64'(3));
      for (int i = 0; i < vecs.size(); i++) begin
         fetch(vecs[i].ce, vecs[i].a, vecs[i].d, vecs[i].v, vecs[i].e, {"s_", vecs[i].name});
      end

      img.delete();
      for (int i = 0; i < 1024; i++) img.push_back(32'(i));
      load_img(0, 1'b0, "full");
      chk("full.count", 64'(load_count), 64'(1024));
      chk("full.busy",  64'(busy),       64'(0));
      load_valid = 1'b1;
      load_data  = 32'hDEADBEEF;
      tick();
      tick();
      load_valid = 1'b0;
      chk("full.extra_busy",  64'(busy),       64'(0));
      chk("full.extra_count", 64'(load_count), 64'(1024));
      fetch(1'b1, 32'hFFC, 32'h3FF, 1'b1, 1'b0, "full_0xffc");
      fetch(1'b1, 32'h4,   32'h1,   1'b1, 1'b0, "full_0x4");
      fetch(1'b1, 32'h800, 32'h200, 1'b1, 1'b0, "full_0x800");

      img = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
      ce = 1'b0;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_data  = img[i];
         tick();
      end
      chk("abort.count_pre", 64'(load_count), 64'(2));
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("abort.count", 64'(load_count), 64'(0));
      chk("abort.busy",  64'(busy),       64'(1));
      load_valid = 1'b0;
      wait_idle("abort_clear", n);
      chk("abort.clear_cycles", 64'(n), 64'(1024));
      fetch(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, "abort_0x0");
      fetch(1'b1, 32'h4, 32'h0, 1'b1, 1'b0, "abort_0x4");

      tick();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: %0d results never checked", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule

`default_nettype wire
